// File: rtl/midi_note_decoder_if.sv
// midi_note_decoder_if: MIDI byte stream from the UART byte receiver.
interface midi_note_decoder_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    modport master (output byte_in, byte_valid);
    modport slave  (input byte_in, byte_valid);
endinterface

// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI stream to melody frequency and drum beat pulse.
// Define MIDI_DRUM_EN to build the drum-channel decoder and beat counter.
module midi_note_decoder #(
    parameter int CHANNEL      = 0,
    parameter int DRUM_CHANNEL = 9,
    parameter int BEAT_CYCLES  = 2500000
) (
    input  logic               clk,
    input  logic               reset_n,
    midi_note_decoder_if.slave midi,
    output logic [11:0]        freq,
    output logic [6:0]         note,
    output logic               note_active,
    output logic               beat,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, WAIT_D1, WAIT_D2, SKIP1, SKIP2, SYSEX} state_t;

    if (CHANNEL == DRUM_CHANNEL || BEAT_CYCLES < 1) begin : g_bad_cfg
        $error("midi_note_decoder: invalid channel or beat configuration");
    end

    state_t      state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [6:0]  d1_q, d1_d;
    logic        ex_d, ex_q, err_d, err_q;
    logic [7:0]  ex_st_q;
    logic [6:0]  ex_key_q, ex_vel_q;
    logic [11:0] freq_q, freq_d, fk;
    logic [6:0]  note_q, note_d;
    logic        act_q, act_d;
    logic [3:0]  hi, ex_hi, oct, pc;
    logic [13:0] scaled;
    logic        mel, key_on, on, off, ano;

    function automatic logic [13:0] base_hz(input logic [3:0] p);
        case (p)
            4'd0:    base_hz = 14'd8372;
            4'd1:    base_hz = 14'd8870;
            4'd2:    base_hz = 14'd9397;
            4'd3:    base_hz = 14'd9956;
            4'd4:    base_hz = 14'd10548;
            4'd5:    base_hz = 14'd11175;
            4'd6:    base_hz = 14'd11840;
            4'd7:    base_hz = 14'd12544;
            4'd8:    base_hz = 14'd13290;
            4'd9:    base_hz = 14'd14080;
            4'd10:   base_hz = 14'd14917;
            4'd11:   base_hz = 14'd15804;
            default: base_hz = 14'd0;
        endcase
    endfunction

    assign hi = midi.byte_in[7:4];

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        d1_d     = d1_q;
        ex_d     = 1'b0;
        err_d    = 1'b0;
        if (midi.byte_valid && midi.byte_in[7]) begin
            // Real-time bytes may arrive anywhere and must not disturb parsing
            if (midi.byte_in[7:3] != 5'b11111) begin
                status_d = midi.byte_in;
                state_d  = hi == 4'hF ? (midi.byte_in == 8'hF0 ? SYSEX : IDLE) :
                           (hi == 4'h8 || hi == 4'h9 || hi == 4'hB) ? WAIT_D1 :
                           (hi == 4'hC || hi == 4'hD) ? SKIP1 : SKIP2;
            end
        end else if (midi.byte_valid) begin
            case (state_q)
                IDLE:    err_d = 1'b1;
                WAIT_D1: begin
                    d1_d    = midi.byte_in[6:0];
                    state_d = WAIT_D2;
                end
                WAIT_D2: begin
                    ex_d    = 1'b1;
                    state_d = WAIT_D1;
                end
                SKIP1:   state_d = (status_q[7:4] == 4'hA || status_q[7:4] == 4'hE) ? SKIP2 : SKIP1;
                SKIP2:   state_d = SKIP1;
                default: state_d = state_q;
            endcase
        end
    end

    // Second stage: the completed message is decoded and the key looked up
    assign ex_hi  = ex_st_q[7:4];
    assign oct    = 4'(ex_key_q / 7'd12);
    assign pc     = 4'(ex_key_q % 7'd12);
    assign scaled = base_hz(pc) >> (4'd10 - oct);
    assign fk     = scaled > 14'd4095 ? 12'hFFF : scaled[11:0];
    assign mel    = ex_q && ex_st_q[3:0] == 4'(CHANNEL);
    assign key_on = ex_hi == 4'h9 && ex_vel_q != 7'd0;
    assign on     = mel && key_on;
    assign off    = mel && (ex_hi == 4'h8 || (ex_hi == 4'h9 && ex_vel_q == 7'd0)) &&
                    ex_key_q == note_q && act_q;
    assign ano    = mel && ex_hi == 4'hB && ex_key_q == 7'd123;

    always_comb begin
        note_d = on ? ex_key_q : note_q;
        act_d  = on ? 1'b1 : (off || ano) ? 1'b0 : act_q;
        freq_d = on ? fk : (off || ano) ? 12'd0 : freq_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            status_q <= 8'd0;
            d1_q     <= 7'd0;
            ex_q     <= 1'b0;
            ex_st_q  <= 8'd0;
            ex_key_q <= 7'd0;
            ex_vel_q <= 7'd0;
            err_q    <= 1'b0;
            freq_q   <= 12'd0;
            note_q   <= 7'd0;
            act_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            d1_q     <= d1_d;
            ex_q     <= ex_d;
            err_q    <= err_d;
            freq_q   <= freq_d;
            note_q   <= note_d;
            act_q    <= act_d;
            if (ex_d) begin
                ex_st_q  <= status_q;
                ex_key_q <= d1_q;
                ex_vel_q <= midi.byte_in[6:0];
            end
        end
    end

`ifdef MIDI_DRUM_EN
    localparam int CW = $clog2(BEAT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drum;

    assign drum = ex_q && ex_st_q[3:0] == 4'(DRUM_CHANNEL) && key_on;

    always_comb begin
        cnt_d = drum ? CW'(BEAT_CYCLES) : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign beat = cnt_q != '0;
`else
    assign beat = 1'b0;
`endif

    assign freq        = freq_q;
    assign note        = note_q;
    assign note_active = act_q;
    assign err         = err_q;
endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: scoreboard bench for the MIDI note decoder.
module tb_midi_note_decoder;
    localparam int BC = 10;
`ifdef MIDI_DRUM_EN
    localparam int BHI1 = 10, BHI2 = 15;
`else
    localparam int BHI1 = 0, BHI2 = 0;
`endif

    typedef struct {
        int         due;
        logic [11:0] f;
        logic [6:0]  n;
        logic        a;
    } upd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] freq;
    logic [6:0]  note;
    logic        note_active, beat, err;
    int          cyc = 0, t_last = 0, errors = 0, checks = 0, bhi = 0, mcnt = 0;
    logic [11:0] ef = 12'd0;
    logic [6:0]  en = 7'd0;
    logic        ea = 1'b0, ee, eb;
    upd_t        uq[$];
    int          eq[$];
    int          bq[$];

    midi_note_decoder_if bus ();

    midi_note_decoder #(.CHANNEL(0), .DRUM_CHANNEL(9), .BEAT_CYCLES(BC)) dut (
        .clk(clk), .reset_n(reset_n), .midi(bus), .freq(freq), .note(note),
        .note_active(note_active), .beat(beat), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: apply expectations that fall due this cycle, then compare every output
    always @(negedge clk) begin
        upd_t u;
        while (uq.size() > 0 && uq[0].due <= cyc) begin
            u = uq.pop_front();
            ef = u.f; en = u.n; ea = u.a;
        end
        ee = 1'b0;
        if (eq.size() > 0 && eq[0] == cyc) begin
            ee = 1'b1;
            void'(eq.pop_front());
        end
        if (bq.size() > 0 && bq[0] == cyc) begin
            void'(bq.pop_front());
            mcnt = BC;
        end else if (mcnt > 0) mcnt--;
        eb = mcnt > 0;
        if (beat === 1'b1) bhi++;
        checks += 5;
        if (freq !== ef) begin errors++; $display("FAIL freq got %0d exp %0d cycle %0d", freq, ef, cyc); end
        if (note !== en) begin errors++; $display("FAIL note got %0d exp %0d cycle %0d", note, en, cyc); end
        if (note_active !== ea) begin errors++; $display("FAIL note_active got %b exp %b cycle %0d", note_active, ea, cyc); end
        if (err !== ee) begin errors++; $display("FAIL err got %b exp %b cycle %0d", err, ee, cyc); end
        if (beat !== eb) begin errors++; $display("FAIL beat got %b exp %b cycle %0d", beat, eb, cyc); end
    end

    task automatic send(input logic [7:0] b);
        bus.byte_in = b;
        bus.byte_valid = 1'b1;
        @(posedge clk); #2;
        bus.byte_valid = 1'b0;
        t_last = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic exp_note(input logic [11:0] f, input logic [6:0] n, input logic a);
        uq.push_back('{t_last + 1, f, n, a});
    endtask

    task automatic exp_err();
        eq.push_back(t_last);
    endtask

    task automatic exp_beat();
`ifdef MIDI_DRUM_EN
        bq.push_back(t_last + 1);
`endif
    endtask

    task automatic rst_assert();
        reset_n = 1'b0;
        uq.delete(); eq.delete(); bq.delete();
        ef = 12'd0; en = 7'd0; ea = 1'b0; mcnt = 0;
    endtask

    task automatic test_reset();
        rst_assert();
        idle(3);
        checks += 3;
        if (freq !== 12'd0) begin errors++; $display("FAIL reset_freq got %0d exp 0", freq); end
        if ({note, note_active} !== 8'd0) begin errors++; $display("FAIL reset_note got %0d/%b exp 0/0", note, note_active); end
        if ({beat, err} !== 2'b00) begin errors++; $display("FAIL reset_beat_err got %b%b exp 00", beat, err); end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_note_on_off();
        send(8'h90); send(8'h45); send(8'h64); exp_note(12'd440, 7'd69, 1'b1);
        idle(2);
        checks++;
        if (freq !== 12'd440) begin errors++; $display("FAIL a4_freq got %0d exp 440", freq); end
        send(8'h80); send(8'h45); send(8'h00); exp_note(12'd0, 7'd69, 1'b0);
        idle(3);
    endtask

    task automatic test_running_status();
        send(8'h90); send(8'h3C); send(8'h40); exp_note(12'd261, 7'd60, 1'b1);
        send(8'h40); send(8'h40); exp_note(12'd329, 7'd64, 1'b1);
        send(8'h3C); send(8'h00);
        idle(2);
        send(8'h40); send(8'h00); exp_note(12'd0, 7'd64, 1'b0);
        idle(3);
    endtask

    task automatic test_realtime();
        send(8'h90); send(8'h6C); send(8'hF8); send(8'h7F); exp_note(12'd4095, 7'd108, 1'b1);
        send(8'hB0); send(8'h07); send(8'h64);
        idle(2);
        send(8'h7B); send(8'h00); exp_note(12'd0, 7'd108, 1'b0);
        idle(3);
    endtask

    task automatic test_range();
        send(8'h90); send(8'h00); send(8'h01); exp_note(12'd8, 7'd0, 1'b1);
        send(8'h6B); send(8'h01); exp_note(12'd3951, 7'd107, 1'b1);
        send(8'h7F); send(8'h01); exp_note(12'd4095, 7'd127, 1'b1);
        send(8'h45); send(8'h00);
        send(8'h91); send(8'h45); send(8'h64);
        send(8'h90); send(8'h7F); send(8'h00); exp_note(12'd0, 7'd127, 1'b0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        send(8'h90); send(8'h45); send(8'h64); exp_note(12'd440, 7'd69, 1'b1);
        send(8'h45); send(8'h00); exp_note(12'd0, 7'd69, 1'b0);
        send(8'h3C); send(8'h40); exp_note(12'd261, 7'd60, 1'b1);
        send(8'h40); send(8'h40); exp_note(12'd329, 7'd64, 1'b1);
        send(8'h40); send(8'h00); exp_note(12'd0, 7'd64, 1'b0);
        idle(3);
    endtask

    task automatic test_err();
        rst_assert();
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send(8'h12); exp_err();
        idle(3);
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h05); exp_err();
        idle(2);
        send(8'hC0); send(8'h05); send(8'h06);
        send(8'hE0); send(8'h01); send(8'h02); send(8'h03);
        send(8'hD3); send(8'h7F); send(8'hA0); send(8'h01); send(8'h02);
        idle(3);
    endtask

    task automatic test_drum();
        bhi = 0;
        send(8'h99); send(8'h24); send(8'h50); exp_beat();
        idle(14);
        checks++;
        if (bhi !== BHI1) begin errors++; $display("FAIL beat_len got %0d exp %0d", bhi, BHI1); end
        bhi = 0;
        send(8'h24); send(8'h50); exp_beat();
        send(8'h24);
        idle(3);
        send(8'h50); exp_beat();
        idle(20);
        checks++;
        if (bhi !== BHI2) begin errors++; $display("FAIL beat_retrig got %0d exp %0d", bhi, BHI2); end
        bhi = 0;
        send(8'h89); send(8'h24); send(8'h00);
        send(8'h99); send(8'h24); send(8'h00);
        idle(12);
        checks++;
        if (bhi !== 0) begin errors++; $display("FAIL beat_off got %0d exp 0", bhi); end
    endtask

    task automatic test_reset_mid();
        send(8'h90); send(8'h45);
        rst_assert();
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send(8'h40); exp_err();
        idle(4);
        checks++;
        if ({freq, note_active} !== 13'd0) begin errors++; $display("FAIL reset_mid got %0d/%b exp 0/0", freq, note_active); end
    endtask

    initial begin
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        @(posedge clk); #2;
        test_reset();
        test_note_on_off();
        test_running_status();
        test_realtime();
        test_range();
        test_back_to_back();
        test_err();
        test_drum();
        test_reset_mid();
        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
